bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one bit per clock.
- Generalised in input width and BCD digit count.
- Adds a start/busy/done handshake and saturating overflow.
- Sits between the reaction-time counter and the 7-segment display driver; replaces the unrolled combinational converter tree to save LUTs at wider widths.

Parameters:
- BIN_W, 14, binary input width in bits; legal 1..32.
- DIGITS, 4, number of BCD output digits; legal 1..10.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only when the block is idle.
- bin  in  BIN_W  unsigned binary value; captured on the accepting edge only.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; bcd and ovf are valid and updated in this cycle.
- bcd  out  4*DIGITS  packed BCD, digit 0 = bits [3:0]; held until the next done.
- ovf  out  1  set if the last converted bin exceeded 10^DIGITS-1; held with bcd.

Behaviour:
- Reset (rst=1 at a rising edge):
  - busy=0, done=0, bcd=0, ovf=0, state=IDLE.
  - Shift register and bit counter are cleared.
  - Reset has priority over every other input.
- States:
  - IDLE: busy=0. start=1 → load work register {DIGITS*4 zeros, bin}, counter=0, capture ovf_pending = (bin > 10^DIGITS-1) → SHIFT.
  - SHIFT: busy=1. Each edge:
    - Every 4-bit digit field of the BCD part gets +3 if its value is >=5 (adjust applied to all digits in parallel).
    - The whole {bcd, bin} work register then shifts left by 1.
    - counter increments.
    - On the edge where counter = BIN_W-1: load bcd/ovf outputs from the post-shift value, set done=1, go to IDLE.
- Timing: start sampled at edge t0.
  - busy=1 after edges t0..t0+BIN_W-1, i.e. exactly BIN_W cycles.
  - After edge t0+BIN_W: busy=0, done=1 for exactly one cycle, bcd/ovf valid.
- done is a registered output and is deasserted on the next edge unconditionally.
- start while busy=1: ignored, with no queueing and no effect on the conversion in flight.
- start in the cycle done=1: accepted, since the block is already IDLE. busy rises on the next edge while bcd keeps the just-delivered value.
- bin changes after the accepting edge: ignored.
- Overflow: if ovf_pending is set, the final load writes bcd = all digits 4'h9 (saturate) and ovf=1. Otherwise bcd = converted value and ovf=0.
- If BIN_W cannot represent a value above 10^DIGITS-1, ovf is constant 0; it must synthesise away.
- Work register width: 4*DIGITS + BIN_W. BCD bits shifted out of the top digit are discarded; they only occur when ovf_pending=1.
- Counter width: $clog2(BIN_W+1). With BIN_W=1 the counter compare still holds: one SHIFT cycle.
- rst asserted mid-conversion: aborts, no done pulse, outputs return to reset values (bcd=0).

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_DIGIT_W = 4
  - BCD_ADJ_THRESH = 5
  - BCD_ADJ_ADD = 3
  - State encoding IDLE=0, SHIFT=1
  - A constant function computing 10^DIGITS-1, used for the overflow threshold.
- One natural sub-module, bcd_digit_adj: combinational 4-bit adjust, out = (in >= BCD_ADJ_THRESH) ? in + BCD_ADJ_ADD : in.
  - Instantiated DIGITS times in a generate loop on the BCD part of the work register.
- FSM, counter and output registers stay in bin2bcd_seq.

Test Plan:
- Defaults (BIN_W=14, DIGITS=4), bin=1234, start pulse at edge t0 → busy high 14 cycles; done=1 after edge t0+14; bcd=16'h1234, ovf=0.
- bin=0 → bcd=16'h0000, ovf=0, done after 14 cycles; bin=9999 → bcd=16'h9999, ovf=0.
- bin=10000 and bin=16383 → bcd=16'h9999, ovf=1 for each; next conversion of bin=42 → bcd=16'h0042, ovf=0.
- bin=500 started, then start pulsed with bin=777 at cycle t0+5 → single done at t0+14 with bcd=16'h0500; the second request is dropped. Then start held high with bin=777 during the done cycle → second done exactly 15 cycles after the first, bcd=16'h0777.
- rst asserted at t0+7 during a conversion of 3210 → busy=0, bcd=0, ovf=0 next cycle, no done pulse; a new start with 3210 then completes normally with 16'h3210.
- Parameter sweep BIN_W=8/DIGITS=3 with all 256 inputs, compared against a reference model (value → decimal digits) → all match, ovf never set. BIN_W=20/DIGITS=5 with random inputs → match, including saturation to 20'h99999 above 99999.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, converter state encoding and the decimal range helper
package bcd_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Largest value representable in the given number of decimal digits (10^digits - 1)
    function automatic logic [63:0] bcd_max(input int digits);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < digits; k++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/busy/done conversion handshake with binary input and BCD result
//   start, bin : requester -> converter
//   busy, done, bcd, ovf : converter -> requester
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (output start, bin, input busy, done, bcd, ovf);
    modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to a BCD digit of 5 or more
//   d : digit before the shift
//   q : corrected digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);
    assign q = (d >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ? d + BCD_DIGIT_W'(BCD_ADJ_ADD) : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter, one bit per clock with saturating overflow
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bin2bcd_seq_if (start/bin in, busy/done/bcd/ovf out)
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int W  = BW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [63:0] MAXV = bcd_max(DIGITS);
    // Overflow logic is only kept when bin can exceed the decimal range
    localparam bit OVF_ON = ((64'd1 << BIN_W) - 64'd1) > MAXV;

    state_t         state, state_n;
    logic [W-1:0]   work, work_n, adj;
    logic [CW-1:0]  cnt, cnt_n;
    logic           pend, pend_n, fin;
    logic [BW-1:0]  bcd_q;
    logic           ovf_q, done_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d(work[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .q(adj[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end
    assign adj[BIN_W-1:0] = work[BIN_W-1:0];

    always_comb begin
        state_n = state;
        work_n  = work;
        cnt_n   = cnt;
        pend_n  = pend;
        fin     = 1'b0;
        if (state == IDLE) begin
            if (bus.start) begin
                state_n = SHIFT;
                work_n  = {{BW{1'b0}}, bus.bin};
                cnt_n   = '0;
                pend_n  = OVF_ON && (64'(bus.bin) > MAXV);
            end
        end else begin
            // Top bit of the adjusted register falls off; only possible when pend is set
            work_n  = W'({adj, 1'b0});
            cnt_n   = cnt + 1'b1;
            fin     = (cnt == CW'(BIN_W - 1));
            state_n = fin ? IDLE : SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            pend   <= 1'b0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            work   <= work_n;
            cnt    <= cnt_n;
            pend   <= pend_n;
            done_q <= fin;
            if (fin) begin
                bcd_q <= pend ? {DIGITS{4'h9}} : work_n[W-1 -: BW];
                ovf_q <= pend;
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and sweep checks of bin2bcd_seq at three parameter sets
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;
    int   nb, k;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) i0 ();
    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) i1 ();
    bin2bcd_seq_if #(.BIN_W(20), .DIGITS(5)) i2 ();

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) u0 (.clk(clk), .rst(rst), .bus(i0));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) u1 (.clk(clk), .rst(rst), .bus(i1));
    bin2bcd_seq #(.BIN_W(20), .DIGITS(5)) u2 (.clk(clk), .rst(rst), .bus(i2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // From a negedge just after the accepting edge, run until done; pulse a second start at loop step p
    task automatic wait0(input int p);
        nb = 0;
        k  = 0;
        while (!i0.done && k < 40) begin
            i0.start = (k == p);
            if (k == p) i0.bin = 14'd777;
            nb += int'(i0.busy);
            k++;
            @(negedge clk);
        end
        i0.start = 1'b0;
        check("done0", i0.done, 1'b1);
    endtask

    task automatic go0(input logic [13:0] v, input int p);
        @(negedge clk);
        i0.start = 1'b1;
        i0.bin   = v;
        @(negedge clk);
        i0.start = 1'b0;
        i0.bin   = 14'($urandom);
        wait0(p);
    endtask

    task automatic go1(input logic [7:0] v);
        @(negedge clk);
        i1.start = 1'b1;
        i1.bin   = v;
        @(negedge clk);
        i1.start = 1'b0;
        k = 0;
        while (!i1.done && k < 30) begin
            k++;
            @(negedge clk);
        end
        check("done1", i1.done, 1'b1);
        check("bcd1", i1.bcd, ref_bcd(v, 3));
        check("ovf1", i1.ovf, 1'b0);
    endtask

    task automatic go2(input logic [19:0] v);
        @(negedge clk);
        i2.start = 1'b1;
        i2.bin   = v;
        @(negedge clk);
        i2.start = 1'b0;
        k = 0;
        while (!i2.done && k < 40) begin
            k++;
            @(negedge clk);
        end
        check("done2", i2.done, 1'b1);
        check("bcd2", i2.bcd, (v > 20'd99999) ? 64'h99999 : ref_bcd(v, 5));
        check("ovf2", i2.ovf, v > 20'd99999);
    endtask

    initial begin
        int nd;
        i0.start = 1'b0; i0.bin = '0;
        i1.start = 1'b0; i1.bin = '0;
        i2.start = 1'b0; i2.bin = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", i0.busy, 1'b0);
        check("rst_done", i0.done, 1'b0);
        check("rst_bcd",  i0.bcd,  16'h0000);
        check("rst_ovf",  i0.ovf,  1'b0);
        rst = 1'b0;

        go0(14'd1234, -1);
        check("lat_1234", k, 14);
        check("busy_1234", nb, 14);
        check("idle_at_done", i0.busy, 1'b0);
        check("bcd_1234", i0.bcd, 16'h1234);
        check("ovf_1234", i0.ovf, 1'b0);
        @(negedge clk);
        check("done_pulse", i0.done, 1'b0);
        check("bcd_hold", i0.bcd, 16'h1234);

        go0(14'd0, -1);
        check("lat_0", k, 14);
        check("bcd_0", i0.bcd, 16'h0000);
        check("ovf_0", i0.ovf, 1'b0);
        go0(14'd9999, -1);
        check("bcd_9999", i0.bcd, 16'h9999);
        check("ovf_9999", i0.ovf, 1'b0);
        go0(14'd10000, -1);
        check("bcd_10000", i0.bcd, 16'h9999);
        check("ovf_10000", i0.ovf, 1'b1);
        go0(14'd16383, -1);
        check("bcd_16383", i0.bcd, 16'h9999);
        check("ovf_16383", i0.ovf, 1'b1);
        go0(14'd42, -1);
        check("bcd_42", i0.bcd, 16'h0042);
        check("ovf_42", i0.ovf, 1'b0);

        go0(14'd500, 4);
        check("lat_500", k, 14);
        check("bcd_500", i0.bcd, 16'h0500);
        // Start during the done cycle is accepted on the next edge
        i0.start = 1'b1;
        i0.bin   = 14'd777;
        @(negedge clk);
        i0.start = 1'b0;
        check("b2b_busy", i0.busy, 1'b1);
        check("b2b_done_clr", i0.done, 1'b0);
        check("b2b_bcd_hold", i0.bcd, 16'h0500);
        wait0(-1);
        check("b2b_gap", k + 1, 15);
        check("bcd_777", i0.bcd, 16'h0777);

        @(negedge clk);
        i0.start = 1'b1;
        i0.bin   = 14'd3210;
        @(negedge clk);
        i0.start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", i0.busy, 1'b0);
        check("abort_bcd", i0.bcd, 16'h0000);
        check("abort_ovf", i0.ovf, 1'b0);
        nd = 0;
        repeat (20) begin
            nd += int'(i0.done);
            @(negedge clk);
        end
        check("abort_no_done", nd, 0);
        go0(14'd3210, -1);
        check("bcd_3210", i0.bcd, 16'h3210);

        for (int v = 0; v < 256; v++) go1(8'(v));

        go2(20'd0);
        go2(20'd99999);
        go2(20'd100000);
        go2(20'd1048575);
        go2(20'd12345);
        repeat (20) go2(20'($urandom_range(0, 1048575)));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
